// File: rtl/sect571k1_pt_check.sv
// ----------------------------------------------------------------------------
// sect571k1_pt_check: tests y^2 + xy == x^3 + 1 over GF(2^571) for (x, y)
// using one time-shared bit-serial MSB-first multiplier.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sect571k1_pt_check (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         start,
  input  logic [570:0] x,
  input  logic [570:0] y,
  output logic         busy,
  output logic         done,
  output logic         on_curve,
  output logic         inf
);

  localparam int unsigned M    = 571;
  localparam logic [M-1:0] FRED = 571'h425;
  localparam logic [9:0]   CNT_TOP = 10'd570;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MYY  = 3'd1,
    S_MXY  = 3'd2,
    S_MXX  = 3'd3,
    S_MX3  = 3'd4,
    S_CMP  = 3'd5
  } state_t;

  state_t       state_q, state_d;
  logic [9:0]   cnt_q, cnt_d;
  logic [M-1:0] x_q, x_d, y_q, y_d;
  logic [M-1:0] t0_q, t0_d, t1_q, t1_d;
  logic [M-1:0] acc_q, acc_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         on_curve_q, on_curve_d;
  logic         inf_q, inf_d;

  logic [M-1:0] op_a, op_b, acc_step;
  logic         pt_is_inf;

  // Operand routing for the shared multiplier
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state_q)
      S_MYY:   begin op_a = y_q;  op_b = y_q; end
      S_MXY:   begin op_a = x_q;  op_b = y_q; end
      S_MXX:   begin op_a = x_q;  op_b = x_q; end
      S_MX3:   begin op_a = t1_q; op_b = x_q; end
      default: begin op_a = '0;   op_b = '0;  end
    endcase
  end

  assign acc_step = {acc_q[M-2:0], 1'b0}
                  ^ (acc_q[M-1] ? FRED : '0)
                  ^ (op_b[cnt_q] ? op_a : '0);

  assign pt_is_inf = (x_q == '0) && (y_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    t0_d       = t0_q;
    t1_d       = t1_q;
    acc_d      = acc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    on_curve_d = on_curve_q;
    inf_d      = inf_q;

    case (state_q)
      S_IDLE: begin
        // done_q high marks the CMP result cycle; a start there is dropped
        if (start && !done_q) begin
          x_d        = x;
          y_d        = y;
          on_curve_d = 1'b0;
          inf_d      = 1'b0;
          busy_d     = 1'b1;
          acc_d      = '0;
          cnt_d      = CNT_TOP;
          state_d    = ((x == '0) && (y == '0)) ? S_CMP : S_MYY;
        end
      end

      S_MYY, S_MXY, S_MXX, S_MX3: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 10'd1;
        if (cnt_q == 10'd0) begin
          acc_d = '0;
          cnt_d = CNT_TOP;
          case (state_q)
            S_MYY:   begin t0_d = acc_step;        state_d = S_MXY; end
            S_MXY:   begin t0_d = t0_q ^ acc_step; state_d = S_MXX; end
            S_MXX:   begin t1_d = acc_step;        state_d = S_MX3; end
            default: begin t1_d = acc_step;        state_d = S_CMP; end
          endcase
        end
      end

      S_CMP: begin
        inf_d      = pt_is_inf;
        on_curve_d = pt_is_inf | (t0_q == (t1_q ^ {{(M-1){1'b0}}, 1'b1}));
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      t0_q       <= '0;
      t1_q       <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      on_curve_q <= 1'b0;
      inf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      t0_q       <= t0_d;
      t1_q       <= t1_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      on_curve_q <= on_curve_d;
      inf_q      <= inf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign on_curve = on_curve_q;
  assign inf      = inf_q;

endmodule

`default_nettype wire

// File: tb/tb_sect571k1_pt_check.sv
// ----------------------------------------------------------------------------
// tb_sect571k1_pt_check: directed and random checks of sect571k1_pt_check
// against a multiply-then-reduce GF(2^571) reference.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sect571k1_pt_check;

  localparam int LAT_PT  = 2285;
  localparam int LAT_INF = 1;
  localparam int BOUND   = 3000;
  localparam logic [1141:0] FPOLY = (1142'b1 << 571) | 1142'h425;

  localparam logic [570:0] GX = 571'h26EB7A8_59923FBC_82189631_F8103FE4_AC9CA297_0012D5D4_60248048_01841CA4_43709584_93B205E6_47DA304D_B4CEB08C_BBD1BA39_494776FB_988B4717_4DCA88C7_E2945283_A01C8972;
  localparam logic [570:0] GY = 571'h349DC80_7F4FBF37_4F4AEADE_3BCA9531_4DD58CEC_9F307A54_FFC61EFC_006D8A2C_9D4979C0_AC44AEA7_4FBEBBB9_F772AEDC_B620B01A_7BA7AF1B_320430C8_591984F6_01CD4C14_3EF1C7A3;

  logic         clk = 1'b0;
  logic         rst, clr, start;
  logic [570:0] x, y;
  logic         busy, done, on_curve, inf;

  int n_cmp = 0;
  int n_mis = 0;

  sect571k1_pt_check dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .start    (start),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .on_curve (on_curve),
    .inf      (inf)
  );

  always #5 clk = ~clk;

  // Schoolbook carry-less product, then polynomial reduction from the top
  function automatic logic [570:0] gmul(input logic [570:0] a, input logic [570:0] b);
    logic [1141:0] p;
    p = '0;
    for (int i = 0; i < 571; i++)
      if (b[i]) p = p ^ ({571'b0, a} << i);
    for (int i = 1141; i >= 571; i--)
      if (p[i]) p = p ^ (FPOLY << (i - 571));
    return p[570:0];
  endfunction

  function automatic logic model_inf(input logic [570:0] px, input logic [570:0] py);
    return (px == '0) && (py == '0);
  endfunction

  function automatic logic model_on(input logic [570:0] px, input logic [570:0] py);
    logic [570:0] lhs, rhs;
    lhs = gmul(py, py) ^ gmul(px, py);
    rhs = gmul(gmul(px, px), px) ^ 571'h1;
    return model_inf(px, py) || (lhs == rhs);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rand_fe(output logic [570:0] v);
    v = '0;
    for (int i = 0; i < 18; i++) v = (v << 32) | 571'($urandom);
  endtask

  // Called #1 after a clock edge; returns #1 after the edge where done is seen
  task automatic start_and_wait(input logic [570:0] px, input logic [570:0] py,
                                input bit noise, output int lat);
    logic [570:0] rx, ry;
    start = 1'b1; x = px; y = py;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= BOUND; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin lat = k; break; end
      if (noise && (k == 5 || k == 600 || k == 2000)) begin
        rand_fe(rx); rand_fe(ry);
        start = 1'b1; x = rx; y = ry;
      end
    end
    start = 1'b0;
  endtask

  task automatic do_check(input string tag, input logic [570:0] px, input logic [570:0] py,
                          input bit noise);
    int  lat;
    logic exp_inf, exp_on;
    exp_inf = model_inf(px, py);
    exp_on  = model_on(px, py);
    start_and_wait(px, py, noise, lat);
    chk({tag, ".latency"}, lat, exp_inf ? LAT_INF : LAT_PT);
    chk({tag, ".on_curve"}, {31'b0, on_curve}, {31'b0, exp_on});
    chk({tag, ".inf"}, {31'b0, inf}, {31'b0, exp_inf});
    chk({tag, ".busy_at_done"}, {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, ".on_curve_held"}, {31'b0, on_curve}, {31'b0, exp_on});
  endtask

  initial begin
    logic [570:0] rx, ry;
    int lat;
    int done_seen;

    rst = 1'b1; clr = 1'b0; start = 1'b0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset.busy", {31'b0, busy}, 32'd0);
    chk("reset.done", {31'b0, done}, 32'd0);
    chk("reset.on_curve", {31'b0, on_curve}, 32'd0);
    chk("reset.inf", {31'b0, inf}, 32'd0);

    do_check("G", GX, GY, 1'b0);
    do_check("G_yflip", GX, GY ^ 571'h1, 1'b0);
    do_check("G_neg", GX, GX ^ GY, 1'b0);
    do_check("inf00", '0, '0, 1'b0);
    do_check("pt01", 571'h0, 571'h1, 1'b0);
    do_check("pt10", 571'h1, 571'h0, 1'b0);
    do_check("pt11", 571'h1, 571'h1, 1'b0);
    do_check("pt20", 571'h2, 571'h0, 1'b0);

    // clr while idle wipes held results
    do_check("G_pre_clr", GX, GY, 1'b0);
    clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
    chk("clr_idle.on_curve", {31'b0, on_curve}, 32'd0);

    // clr mid-operation aborts without done
    start = 1'b1; x = GX; y = GY;
    @(posedge clk); #1 start = 1'b0;
    done_seen = 0;
    for (int k = 1; k < 1000; k++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    chk("clr_mid.busy_before", {31'b0, busy}, 32'd1);
    clr = 1'b1; @(posedge clk); #1 clr = 1'b0;
    chk("clr_mid.busy", {31'b0, busy}, 32'd0);
    chk("clr_mid.on_curve", {31'b0, on_curve}, 32'd0);
    chk("clr_mid.inf", {31'b0, inf}, 32'd0);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    chk("clr_mid.no_done", done_seen, 32'd0);
    do_check("G_after_clr", GX, GY, 1'b0);

    // starts during busy must not disturb the latched operands
    do_check("G_noise", GX, GY, 1'b1);
    do_check("yflip_noise", GX, GY ^ 571'h1, 1'b1);

    // start coincident with done is dropped
    start_and_wait(GX, GY, 1'b0, lat);
    chk("done_start.latency", lat, LAT_PT);
    start = 1'b1; x = 571'h1; y = 571'h0;
    @(posedge clk); #1 start = 1'b0;
    chk("done_start.busy", {31'b0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_start.still_idle", {31'b0, busy | done}, 32'd0);
    chk("done_start.held", {31'b0, on_curve}, {31'b0, model_on(GX, GY)});

    for (int i = 0; i < 5; i++) begin
      rand_fe(rx); rand_fe(ry);
      case (i)
        1: do_check("rand_neg_G", GX, GY ^ GX, 1'b0);
        2: do_check("rand_x_y0", rx, 571'h0, 1'b0);
        default: do_check("rand_xy", rx, ry, 1'b0);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
